// File: rtl/anita3_readout_sequencer_if.sv
// anita3_readout_sequencer_if: digitize request, digitizer, readout and buffer-release signals of the readout sequencer
interface anita3_readout_sequencer_if #(parameter int EVCNT_WIDTH = 32);
  logic                   digitize;
  logic [1:0]             digitize_buffer;
  logic [3:0]             digitize_source;
  logic                   dig_start;
  logic [1:0]             dig_buffer;
  logic                   dig_done;
  logic                   readout_valid;
  logic                   readout_ready;
  logic [1:0]             readout_buffer;
  logic [3:0]             readout_source;
  logic [EVCNT_WIDTH-1:0] readout_event;
  logic                   readout_done;
  logic                   clear;
  logic [1:0]             clear_buffer;
  logic [2:0]             pending;
  logic                   overflow;
  logic                   timeout;
  logic                   err_clear;
  modport master (
    input  digitize, digitize_buffer, digitize_source, dig_done, readout_ready, readout_done, err_clear,
    output dig_start, dig_buffer, readout_valid, readout_buffer, readout_source, readout_event,
           clear, clear_buffer, pending, overflow, timeout
  );
  modport slave (
    output digitize, digitize_buffer, digitize_source, dig_done, readout_ready, readout_done, err_clear,
    input  dig_start, dig_buffer, readout_valid, readout_buffer, readout_source, readout_event,
           clear, clear_buffer, pending, overflow, timeout
  );
endinterface

// File: rtl/anita3_readout_sequencer.sv
// anita3_readout_sequencer: queues digitize requests, runs the digitizer, hands events to readout and releases buffers
module anita3_readout_sequencer #(
  parameter int NUM_HOLD    = 4,
  parameter int EVCNT_WIDTH = 32,
  parameter int DIG_TIMEOUT = 4096
) (
  input logic clk250_i,
  input logic rst_n_i,
  anita3_readout_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, DIG, READ, RWAIT, CLEAR} state_t;
  localparam int PW = NUM_HOLD > 1 ? $clog2(NUM_HOLD) : 1;
  state_t state, state_n;
  logic digitize_q, push_pend, push, pop, full, ovf_set, tmo_set, hs, live;
  logic [5:0] push_data, cur;
  logic [5:0] mem [NUM_HOLD];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic [15:0] timer;
  logic [EVCNT_WIDTH-1:0] evcnt, cur_ev;
  logic overflow, timeout;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(NUM_HOLD - 1) ? '0 : p + PW'(1);
  endfunction
  assign full    = count == 3'(NUM_HOLD);
  assign pop     = state == IDLE && count != 3'd0;
  assign push    = push_pend && (!full || pop);
  assign ovf_set = push_pend && full && !pop;
  assign hs      = state == READ && bus.readout_ready;
  assign tmo_set = state == DIG && timer == 16'(DIG_TIMEOUT - 1) && !bus.dig_done;
  // queue storage; the occupancy counter alone defines which slots are valid
  always_ff @(posedge clk250_i)
    if (push) mem[wr_ptr] <= push_data;
  // edge capture, queue pointers, current event, counters and sticky flags
  always_ff @(posedge clk250_i or negedge rst_n_i)
    if (!rst_n_i) begin
      digitize_q <= 1'b0;
      push_pend  <= 1'b0;
      push_data  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= IDLE;
      timer      <= '0;
      cur        <= '0;
      cur_ev     <= '0;
      evcnt      <= '0;
      overflow   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      digitize_q <= bus.digitize;
      push_pend  <= bus.digitize & ~digitize_q;
      if (bus.digitize & ~digitize_q) push_data <= {bus.digitize_buffer, bus.digitize_source};
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop) rd_ptr <= nxt(rd_ptr);
      count      <= count + {2'b0, push} - {2'b0, pop};
      state      <= state_n;
      timer      <= state == DIG ? timer + 16'd1 : '0;
      if (pop) begin
        cur    <= mem[rd_ptr];
        cur_ev <= evcnt;
      end
      if (hs) evcnt <= evcnt + EVCNT_WIDTH'(1);
      overflow   <= ovf_set | (overflow & ~bus.err_clear);
      timeout    <= tmo_set | (timeout & ~bus.err_clear);
    end
  // next state and event-path outputs; done is ignored on the first DIG cycle
  always_comb begin
    state_n = state;
    live    = state != IDLE;
    case (state)
      IDLE:    state_n = pop ? DIG : IDLE;
      DIG:     state_n = bus.dig_done && timer != 16'd0 ? READ : tmo_set ? CLEAR : DIG;
      READ:    state_n = bus.readout_ready ? RWAIT : READ;
      RWAIT:   state_n = bus.readout_done ? CLEAR : RWAIT;
      default: state_n = IDLE;
    endcase
    bus.dig_start      = state == DIG && timer == 16'd0;
    bus.dig_buffer     = live ? cur[5:4] : '0;
    bus.readout_valid  = state == READ;
    bus.readout_buffer = live ? cur[5:4] : '0;
    bus.readout_source = live ? cur[3:0] : '0;
    bus.readout_event  = live ? cur_ev : '0;
    bus.clear          = state == CLEAR;
    bus.clear_buffer   = state == CLEAR ? cur[5:4] : '0;
    bus.pending        = count;
    bus.overflow       = overflow;
    bus.timeout        = timeout;
  end
endmodule
